// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: multi-cycle fetch/execute sequencer for the RV32I core.
// It fetches the word at ProgAddr over a req/ack handshake, holds it for the
// datapath during execute, then issues a one-cycle PC update pulse that carries
// the branch controls decoded from the opcode.
//
// Handshake: IMemReq is held high for every FETCH cycle while the address is
// word aligned. A transfer completes in the first cycle where IMemReq and
// IMemAck are both high, and IMemData is captured on that edge. IMemAck is
// ignored in every other cycle. ExecDone is sampled only during EXEC.
module pc_fetch_seq #(
  parameter int dataW       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  output logic             IMemReq,
  output logic [dataW-1:0] IMemAddr,
  input  logic             IMemAck,
  input  logic [31:0]      IMemData,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  input  logic             ExecDone,
  input  logic             Halt,
  output logic             PCUpdate,
  output logic             TestBranch,
  output logic             AlwaysBranch,
  output logic             AbsoluteBranch,
  output logic [2:0]       PCBranchType,
  output logic [31:0]      InstrCount,
  output logic             Fault,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Wide enough to hold MEM_TIMEOUT; the counter never exceeds MEM_TIMEOUT-1.
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   instr_q;
  logic [31:0]   count_q;
  logic          addr_ok;
  logic          fetch_hit;
  logic          instr_legal;

  // A misaligned PC suppresses the request entirely; only aligned fetches go out.
  assign addr_ok     = (ProgAddr[1:0] == 2'b00);
  assign fetch_hit   = (state == S_FETCH) && addr_ok && IMemAck;
  // RV32I has no compressed encodings, so the low two bits must be 2'b11.
  assign instr_legal = (IMemData[1:0] == 2'b11);

  // Next-state decode; Halt is only looked at on instruction boundaries.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = Halt ? S_HALTED : S_FETCH;
      S_FETCH: begin
        if (!addr_ok) begin
          state_next = S_FAULT;
        end else if (IMemAck) begin
          state_next = instr_legal ? S_EXEC : S_FAULT;
        end else if (wait_cnt == CNT_LAST) begin
          // No ack by the last allowed cycle: the memory is considered dead.
          state_next = S_FAULT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_EXEC:   state_next = ExecDone ? S_UPDATE : S_EXEC;
      S_UPDATE: state_next = Halt ? S_HALTED : S_FETCH;
      S_HALTED: state_next = Halt ? S_HALTED : S_FETCH;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FAULT;
    endcase
  end

  // State register; FAULT is sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch wait counter: zero on every FETCH entry, counts unacknowledged cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state != S_FETCH) begin
      wait_cnt <= '0;
    end else if (!IMemAck && (wait_cnt != CNT_LAST)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Instruction latch: captured on the acknowledged fetch edge, legal or not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= 32'h0;
    end else if (fetch_hit) begin
      instr_q <= IMemData;
    end
  end

  // Retired-instruction counter; advances on the edge that ends UPDATE and wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 32'h0;
    end else if (state == S_UPDATE) begin
      count_q <= count_q + 32'd1;
    end
  end

  // Moore output decode, plus the combinational fetch address.
  always_comb begin
    IMemReq        = (state == S_FETCH) && addr_ok;
    IMemAddr       = IMemReq ? ProgAddr : '0;
    InstrValid     = (state == S_EXEC);
    PCUpdate       = (state == S_UPDATE);
    TestBranch     = 1'b0;
    AlwaysBranch   = 1'b0;
    AbsoluteBranch = 1'b0;
    PCBranchType   = 3'b000;
    Fault          = (state == S_FAULT);
    if (state == S_UPDATE) begin
      case (instr_q[6:0])
        OP_JAL: begin
          AlwaysBranch = 1'b1;
        end
        OP_JALR: begin
          AlwaysBranch   = 1'b1;
          AbsoluteBranch = 1'b1;
        end
        OP_BRANCH: begin
          TestBranch   = 1'b1;
          PCBranchType = instr_q[14:12];
        end
        default: begin
          TestBranch = 1'b0;
        end
      endcase
    end
  end

  assign Instr      = instr_q;
  assign InstrCount = count_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq: directed scenarios for the fetch/execute sequencer.
module tb_pc_fetch_seq;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ProgAddr = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        ExecDone = 1'b0;
  logic        Halt = 1'b0;
  logic        PCUpdate;
  logic        TestBranch;
  logic        AlwaysBranch;
  logic        AbsoluteBranch;
  logic [2:0]  PCBranchType;
  logic [31:0] InstrCount;
  logic        Fault;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  pc_fetch_seq #(.dataW(32), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .IMemReq(IMemReq),
    .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData), .Instr(Instr),
    .InstrValid(InstrValid), .ExecDone(ExecDone), .Halt(Halt), .PCUpdate(PCUpdate),
    .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
    .AbsoluteBranch(AbsoluteBranch), .PCBranchType(PCBranchType),
    .InstrCount(InstrCount), .Fault(Fault), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds reset, then releases it mid-cycle; the sequencer is then in IDLE.
  task automatic do_reset();
    reset = 1'b0;
    IMemAck = 1'b0; ExecDone = 1'b0; Halt = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if ({IMemReq, IMemAddr, Instr, InstrValid, PCUpdate} !== 67'h0) begin errors++; $display("FAIL reset_io: req=%b addr=%h instr=%h valid=%b upd=%b want all 0", IMemReq, IMemAddr, Instr, InstrValid, PCUpdate); end
    checks++; if ({TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType, InstrCount, Fault} !== 39'h0) begin errors++; $display("FAIL reset_ctrl: tb=%b ab=%b abs=%b type=%b cnt=%0d fault=%b want all 0", TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType, InstrCount, Fault); end
  endtask

  task automatic test_sequential();
    do_reset();
    ProgAddr = 32'h0; IMemData = 32'h0000_0013; IMemAck = 1'b1; ExecDone = 1'b1;
    tick();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || dbg_state !== S_FETCH) begin errors++; $display("FAIL seq_fetch: req=%b addr=%h st=%0d want 1 0 %0d", IMemReq, IMemAddr, dbg_state, S_FETCH); end
    tick();
    checks++; if (InstrValid !== 1'b1 || Instr !== 32'h13 || PCUpdate !== 1'b0) begin errors++; $display("FAIL seq_exec: valid=%b instr=%h upd=%b want 1 13 0", InstrValid, Instr, PCUpdate); end
    tick();
    checks++; if (PCUpdate !== 1'b1 || {TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType} !== 6'b0) begin errors++; $display("FAIL seq_update: upd=%b ctl=%b%b%b type=%b want 1 000 000", PCUpdate, TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType); end
    checks++; if (InstrCount !== 32'd0) begin errors++; $display("FAIL seq_count_in_update: got %0d want 0", InstrCount); end
    tick();
    checks++; if (InstrCount !== 32'd1 || PCUpdate !== 1'b0 || dbg_state !== S_FETCH) begin errors++; $display("FAIL seq_after: cnt=%0d upd=%b st=%0d want 1 0 %0d", InstrCount, PCUpdate, dbg_state, S_FETCH); end
  endtask

  task automatic test_jal_jalr();
    do_reset();
    ProgAddr = 32'h100; IMemData = 32'h0000_006F; IMemAck = 1'b1; ExecDone = 1'b1;
    tick(); tick(); tick();
    checks++; if (PCUpdate !== 1'b1 || AlwaysBranch !== 1'b1 || AbsoluteBranch !== 1'b0 || TestBranch !== 1'b0) begin errors++; $display("FAIL jal_update: upd=%b ab=%b abs=%b tb=%b want 1 1 0 0", PCUpdate, AlwaysBranch, AbsoluteBranch, TestBranch); end
    IMemData = 32'h0000_0067;
    tick();
    checks++; if (AlwaysBranch !== 1'b0 || dbg_state !== S_FETCH) begin errors++; $display("FAIL jal_ctrl_drop: ab=%b st=%0d want 0 %0d", AlwaysBranch, dbg_state, S_FETCH); end
    tick(); tick();
    checks++; if (PCUpdate !== 1'b1 || AlwaysBranch !== 1'b1 || AbsoluteBranch !== 1'b1 || TestBranch !== 1'b0) begin errors++; $display("FAIL jalr_update: upd=%b ab=%b abs=%b tb=%b want 1 1 1 0", PCUpdate, AlwaysBranch, AbsoluteBranch, TestBranch); end
    tick();
    checks++; if (InstrCount !== 32'd2) begin errors++; $display("FAIL jalr_count: got %0d want 2", InstrCount); end
  endtask

  task automatic test_bne_delayed();
    do_reset();
    ProgAddr = 32'h40; IMemData = 32'h0000_1063; IMemAck = 1'b0; ExecDone = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) IMemAck = 1'b1;
      #1;
      checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin errors++; $display("FAIL bne_req_c%0d: req=%b addr=%h want 1 40", i, IMemReq, IMemAddr); end
    end
    tick();
    IMemAck = 1'b0;
    checks++; if (IMemReq !== 1'b0 || IMemAddr !== 32'h0 || InstrValid !== 1'b1) begin errors++; $display("FAIL bne_exec: req=%b addr=%h valid=%b want 0 0 1", IMemReq, IMemAddr, InstrValid); end
    tick();
    checks++; if (TestBranch !== 1'b1 || PCBranchType !== 3'b001 || AlwaysBranch !== 1'b0 || PCUpdate !== 1'b1) begin errors++; $display("FAIL bne_update: tb=%b type=%b ab=%b upd=%b want 1 001 0 1", TestBranch, PCBranchType, AlwaysBranch, PCUpdate); end
  endtask

  task automatic test_timeout_accept();
    do_reset();
    ProgAddr = 32'h0; IMemData = 32'h0000_0013; IMemAck = 1'b0; ExecDone = 1'b0;
    tick();
    repeat (14) tick();
    checks++; if (dbg_state !== S_FETCH || Fault !== 1'b0) begin errors++; $display("FAIL tmo_cycle15: st=%0d fault=%b want %0d 0", dbg_state, Fault, S_FETCH); end
    IMemAck = 1'b1;
    tick();
    IMemAck = 1'b0;
    checks++; if (InstrValid !== 1'b1 || Fault !== 1'b0 || Instr !== 32'h13) begin errors++; $display("FAIL tmo_accept: valid=%b fault=%b instr=%h want 1 0 13", InstrValid, Fault, Instr); end
  endtask

  task automatic test_timeout_fault();
    do_reset();
    ProgAddr = 32'h0; IMemData = 32'h0000_0013; IMemAck = 1'b0; ExecDone = 1'b0;
    tick();
    repeat (14) tick();
    checks++; if (IMemReq !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL tmo_last_wait: req=%b fault=%b want 1 0", IMemReq, Fault); end
    tick();
    checks++; if (Fault !== 1'b1 || IMemReq !== 1'b0) begin errors++; $display("FAIL tmo_fault: fault=%b req=%b want 1 0", Fault, IMemReq); end
    IMemAck = 1'b1; ExecDone = 1'b1;
    repeat (4) tick();
    checks++; if (Fault !== 1'b1 || PCUpdate !== 1'b0 || InstrValid !== 1'b0 || IMemReq !== 1'b0) begin errors++; $display("FAIL tmo_sticky: fault=%b upd=%b valid=%b req=%b want 1 0 0 0", Fault, PCUpdate, InstrValid, IMemReq); end
    #2 reset = 1'b0;
    #1;
    checks++; if (Fault !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL tmo_reset_clear: fault=%b st=%0d want 0 %0d", Fault, dbg_state, S_IDLE); end
  endtask

  task automatic test_misaligned();
    int req_seen;
    do_reset();
    req_seen = 0;
    ProgAddr = 32'h2; IMemData = 32'h0000_0013; IMemAck = 1'b1; ExecDone = 1'b1;
    tick();
    checks++; if (dbg_state !== S_FETCH || IMemReq !== 1'b0 || IMemAddr !== 32'h0) begin errors++; $display("FAIL mis_fetch: st=%0d req=%b addr=%h want %0d 0 0", dbg_state, IMemReq, IMemAddr, S_FETCH); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IMemReq !== 1'b0) req_seen++;
    end
    checks++; if (Fault !== 1'b1 || req_seen != 0) begin errors++; $display("FAIL mis_fault: fault=%b req_cycles=%0d want 1 0", Fault, req_seen); end
  endtask

  task automatic test_illegal();
    int upd_seen;
    do_reset();
    upd_seen = 0;
    ProgAddr = 32'h0; IMemData = 32'h0000_0000; IMemAck = 1'b1; ExecDone = 1'b1;
    tick(); tick();
    checks++; if (Fault !== 1'b1 || InstrValid !== 1'b0) begin errors++; $display("FAIL ill_fault: fault=%b valid=%b want 1 0", Fault, InstrValid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (PCUpdate !== 1'b0) upd_seen++;
    end
    checks++; if (upd_seen != 0 || InstrCount !== 32'd0) begin errors++; $display("FAIL ill_no_update: upd_cycles=%0d cnt=%0d want 0 0", upd_seen, InstrCount); end
  endtask

  task automatic test_halt();
    do_reset();
    Halt = 1'b1; ProgAddr = 32'h8; IMemData = 32'h0000_0013; IMemAck = 1'b1; ExecDone = 1'b0;
    tick();
    checks++; if (dbg_state !== S_HALTED || IMemReq !== 1'b0) begin errors++; $display("FAIL halt_idle: st=%0d req=%b want %0d 0", dbg_state, IMemReq, S_HALTED); end
    Halt = 1'b0;
    tick();
    checks++; if (dbg_state !== S_FETCH || IMemReq !== 1'b1) begin errors++; $display("FAIL halt_release1: st=%0d req=%b want %0d 1", dbg_state, IMemReq, S_FETCH); end
    tick();
    Halt = 1'b1;
    tick();
    checks++; if (InstrValid !== 1'b1 || PCUpdate !== 1'b0) begin errors++; $display("FAIL halt_exec: valid=%b upd=%b want 1 0", InstrValid, PCUpdate); end
    ExecDone = 1'b1;
    tick();
    checks++; if (PCUpdate !== 1'b1) begin errors++; $display("FAIL halt_update: upd=%b want 1", PCUpdate); end
    tick();
    checks++; if (dbg_state !== S_HALTED || IMemReq !== 1'b0 || PCUpdate !== 1'b0 || InstrCount !== 32'd1) begin errors++; $display("FAIL halt_halted: st=%0d req=%b upd=%b cnt=%0d want %0d 0 0 1", dbg_state, IMemReq, PCUpdate, InstrCount, S_HALTED); end
    tick();
    checks++; if (dbg_state !== S_HALTED) begin errors++; $display("FAIL halt_hold: st=%0d want %0d", dbg_state, S_HALTED); end
    Halt = 1'b0;
    tick();
    checks++; if (dbg_state !== S_FETCH || IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin errors++; $display("FAIL halt_resume: st=%0d req=%b addr=%h want %0d 1 8", dbg_state, IMemReq, IMemAddr, S_FETCH); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    ProgAddr = 32'h10; IMemData = 32'h0000_006F; IMemAck = 1'b1; ExecDone = 1'b1;
    tick(); tick(); tick();
    IMemAck = 1'b0;
    tick();
    checks++; if (dbg_state !== S_FETCH || InstrCount !== 32'd1 || Instr !== 32'h6F) begin errors++; $display("FAIL rst_pre: st=%0d cnt=%0d instr=%h want %0d 1 6f", dbg_state, InstrCount, Instr, S_FETCH); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || IMemReq !== 1'b0 || IMemAddr !== 32'h0 || Instr !== 32'h0 || InstrCount !== 32'd0) begin errors++; $display("FAIL rst_async: st=%0d req=%b addr=%h instr=%h cnt=%0d want 0 0 0 0 0", dbg_state, IMemReq, IMemAddr, Instr, InstrCount); end
    checks++; if ({InstrValid, PCUpdate, TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType, Fault} !== 9'h0) begin errors++; $display("FAIL rst_async_ctrl: valid=%b upd=%b ctl=%b%b%b type=%b fault=%b want 0", InstrValid, PCUpdate, TestBranch, AlwaysBranch, AbsoluteBranch, PCBranchType, Fault); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal_jalr();
    test_bne_delayed();
    test_timeout_accept();
    test_timeout_fault();
    test_misaligned();
    test_illegal();
    test_halt();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
